// File: rtl/line_buf_window.sv
// line_buf_window: vertical column former for a sliding-window datapath.
// Keeps the previous NUM_ROWS-1 image lines in a dual-port memory. For every
// accepted pixel it emits the NUM_ROWS-deep column at the same x position,
// one cycle later. After reset the memory is cleared (INIT) before pixels are
// accepted.
//
// Optional feature macro: LINEBUF_BORDER_REPLICATE_EN
//   defined   : unfilled slices replicate the oldest filled slice (top-edge replicate)
//   undefined : unfilled slices read as zero (zero padding)
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   cfg_width      pixels per line, sampled on an accepted SOF pixel (clamped to 2..MAX_WIDTH)
//   in_valid/in_ready/in_sof/in_data   pixel input handshake
//   out_valid      output column valid (one cycle after acceptance)
//   out_col_data   column, MSB slice = oldest line, LSB slice = current pixel
//   out_row_mask   bit k set when slice k holds real data
//   out_eol        output pixel is the last of its line
//   init_busy      memory clear in progress
module line_buf_window #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned NUM_ROWS  = 4,
    parameter int unsigned MAX_WIDTH = 512,
    parameter int unsigned ADDR_W    = 9
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W:0]              cfg_width,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_sof,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_valid,
    output logic [NUM_ROWS*DATA_W-1:0]   out_col_data,
    output logic [NUM_ROWS-1:0]          out_row_mask,
    output logic                         out_eol,
    output logic                         init_busy
);

    localparam int unsigned MEM_W = (NUM_ROWS - 1) * DATA_W;
    localparam int unsigned RF_W  = $clog2(NUM_ROWS);
    localparam int unsigned WID_W = ADDR_W + 1;

    localparam logic [WID_W-1:0]  MAX_W_V  = WID_W'(MAX_WIDTH);
    localparam logic [WID_W-1:0]  MIN_W_V  = WID_W'(2);
    localparam logic [RF_W-1:0]   RF_MAX   = RF_W'(NUM_ROWS - 1);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(MAX_WIDTH - 1);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] col;
    logic [RF_W-1:0]   rows_filled;
    logic [WID_W-1:0]  width_q;

    logic [ADDR_W-1:0] col_q;
    logic [DATA_W-1:0] pix_q;
    logic [MEM_W-1:0]  rd_word;
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  mem [MAX_WIDTH];

    logic              accept;
    logic [WID_W-1:0]  eff_width;
    logic [ADDR_W-1:0] eff_col;
    logic [RF_W-1:0]   eff_rows;
    logic              last_col;
    logic [NUM_ROWS-1:0] mask_nxt;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave INIT once the last address has been cleared
    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  if (clr_addr == CLR_LAST) state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_INIT;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        in_ready  = 1'b0;
        init_busy = 1'b0;
        case (state)
            S_INIT:  init_busy = 1'b1;
            S_RUN:   in_ready  = 1'b1;
            default: init_busy = 1'b1;
        endcase
    end

    // Clear address walks the memory during INIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_addr <= '0;
        end else if (state == S_INIT) begin
            clr_addr <= clr_addr + ADDR_W'(1);
        end
    end

    assign accept = in_valid & in_ready;

    // SOF overrides position and width for the SOF pixel itself
    always_comb begin
        eff_width = width_q;
        eff_col   = col;
        eff_rows  = rows_filled;
        if (in_sof) begin
            eff_col  = '0;
            eff_rows = '0;
            if (cfg_width < MIN_W_V) begin
                eff_width = MIN_W_V;
            end else if (cfg_width > MAX_W_V) begin
                eff_width = MAX_W_V;
            end else begin
                eff_width = cfg_width;
            end
        end
        last_col = ({1'b0, eff_col} == (eff_width - WID_W'(1)));
        for (int k = 0; k < int'(NUM_ROWS); k++) begin
            mask_nxt[k] = (RF_W'(k) <= eff_rows);
        end
    end

    // Position tracking and registered output side-band
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col          <= '0;
            rows_filled  <= '0;
            width_q      <= MAX_W_V;
            col_q        <= '0;
            pix_q        <= '0;
            out_valid    <= 1'b0;
            out_row_mask <= '0;
            out_eol      <= 1'b0;
        end else begin
            out_valid    <= accept;
            out_row_mask <= '0;
            out_eol      <= 1'b0;
            if (accept) begin
                width_q      <= eff_width;
                col          <= last_col ? '0 : eff_col + ADDR_W'(1);
                rows_filled  <= (last_col && (eff_rows != RF_MAX)) ? eff_rows + RF_W'(1) : eff_rows;
                col_q        <= eff_col;
                pix_q        <= in_data;
                out_row_mask <= mask_nxt;
                out_eol      <= last_col;
            end
        end
    end

    // Shift the column history up one line and insert the new pixel
    assign wr_word = MEM_W'({rd_word, pix_q});

    // Line memory: read at accept, write-back one cycle later (read-before-write)
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_word <= mem[eff_col];
        end
        if (state == S_INIT) begin
            mem[clr_addr] <= '0;
        end else if (out_valid) begin
            mem[col_q] <= wr_word;
        end
    end

    logic [DATA_W-1:0] raw [NUM_ROWS];
    logic [DATA_W-1:0] fill;

    always_comb begin
        raw[0] = pix_q;
        for (int k = 1; k < int'(NUM_ROWS); k++) begin
            raw[k] = rd_word[(k-1)*DATA_W +: DATA_W];
        end
    end

`ifdef LINEBUF_BORDER_REPLICATE_EN
    logic [RF_W-1:0] rf_q;

    // Oldest filled slice index, used as the padding source
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_q <= '0;
        end else if (accept) begin
            rf_q <= eff_rows;
        end
    end

    assign fill = raw[rf_q];
`else
    assign fill = '0;
`endif

    // Column assembly with unfilled slices padded
    always_comb begin
        out_col_data = '0;
        if (out_valid) begin
            for (int k = 0; k < int'(NUM_ROWS); k++) begin
                out_col_data[k*DATA_W +: DATA_W] = out_row_mask[k] ? raw[k] : fill;
            end
        end
    end

endmodule

// File: tb/tb_line_buf_window.sv
// Bench for line_buf_window: per-column pixel history model, randomized traffic.
module tb_line_buf_window;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int MW = 512;
    localparam int AW = 9;

`ifdef LINEBUF_BORDER_REPLICATE_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [AW:0]        cfg_width;
    logic               in_valid;
    logic               in_ready;
    logic               in_sof;
    logic [DW-1:0]      in_data;
    logic               out_valid;
    logic [NR*DW-1:0]   out_col_data;
    logic [NR-1:0]      out_row_mask;
    logic               out_eol;
    logic               init_busy;

    line_buf_window #(
        .DATA_W(DW), .NUM_ROWS(NR), .MAX_WIDTH(MW), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .cfg_width(cfg_width),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_data(in_data),
        .out_valid(out_valid), .out_col_data(out_col_data), .out_row_mask(out_row_mask),
        .out_eol(out_eol), .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    int checks;
    int errors;

    // Model: per column, the pixels written there, most recent first
    logic [DW-1:0]    hist [MW][NR-1];
    int               m_col;
    int               m_rows;
    int               m_width;
    int               k_since;
    int               first_ready;
    int               first_valid;

    bit               exp_v;
    logic [NR*DW-1:0] exp_data;
    logic [NR-1:0]    exp_mask;
    bit               exp_eol;
    int               exp_tag;

    logic [NR*DW-1:0] cap_data [64];
    logic [NR-1:0]    cap_mask [64];
    bit               cap_eol  [64];

    task automatic check1(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int clampw(input int w);
        if (w < 2) return 2;
        if (w > MW) return MW;
        return w;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < MW; c++)
            for (int k = 0; k < NR-1; k++)
                hist[c][k] = '0;
        m_col = 0; m_rows = 0; m_width = MW; k_since = 0;
        exp_v = 1'b0; first_ready = -1; first_valid = -1;
    endtask

    task automatic clear_caps();
        for (int i = 0; i < 64; i++) begin
            cap_data[i] = 'x; cap_mask[i] = 'x; cap_eol[i] = 1'b0;
        end
    endtask

    task automatic model_accept(input bit sof, input logic [DW-1:0] d, input int w, input int tag);
        logic [DW-1:0] raw [NR];
        if (sof) begin
            m_width = clampw(w); m_col = 0; m_rows = 0;
        end
        raw[0] = d;
        for (int k = 1; k < NR; k++) raw[k] = hist[m_col][k-1];
        exp_data = '0;
        exp_mask = '0;
        for (int k = 0; k < NR; k++) begin
            if (k <= m_rows) begin
                exp_mask[k] = 1'b1;
                exp_data[k*DW +: DW] = raw[k];
            end else begin
                exp_data[k*DW +: DW] = REP ? raw[m_rows] : '0;
            end
        end
        exp_eol = (m_col == m_width - 1);
        exp_tag = tag;
        for (int k = NR-2; k >= 1; k--) hist[m_col][k] = hist[m_col][k-1];
        hist[m_col][0] = d;
        if (exp_eol) begin
            m_col = 0;
            if (m_rows < NR-1) m_rows++;
        end else begin
            m_col++;
        end
    endtask

    // One cycle: compare last cycle's expectation, then drive new inputs
    task automatic step(input bit v, input bit sof, input logic [DW-1:0] d, input int w, input int tag);
        @(negedge clk);
        k_since++;
        check1("in_ready", in_ready, k_since >= MW);
        check1("init_busy", init_busy, k_since < MW);
        check1("out_valid", out_valid, exp_v);
        if (in_ready && first_ready < 0) first_ready = k_since;
        if (out_valid && first_valid < 0) first_valid = k_since;
        if (exp_v) begin
            check1("out_col_data", out_col_data, exp_data);
            check1("out_row_mask", out_row_mask, exp_mask);
            check1("out_eol", out_eol, exp_eol);
            if (exp_tag >= 0 && exp_tag < 64) begin
                cap_data[exp_tag] = out_col_data;
                cap_mask[exp_tag] = out_row_mask;
                cap_eol[exp_tag]  = out_eol;
            end
        end
        in_valid  = v;
        in_sof    = sof;
        in_data   = d;
        cfg_width = (AW+1)'(w);
        exp_v     = v && in_ready;
        if (exp_v) model_accept(sof, d, w, tag);
    endtask

    initial begin
        logic [NR*DW-1:0] lit;
        int n;
        int tag;
        checks = 0; errors = 0;
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; cfg_width = '0;
        model_reset();
        clear_caps();
        repeat (3) @(negedge clk);
        check1("rst_out_valid", out_valid, 0);
        check1("rst_init_busy", init_busy, 1);
        check1("rst_in_ready", in_ready, 0);
        check1("rst_mask", out_row_mask, 0);
        check1("rst_eol", out_eol, 0);
        check1("rst_data", out_col_data, 0);
        rst = 1'b0;

        // INIT with in_valid held high
        for (int i = 0; i < 515; i++) step(1'b1, 1'b0, DW'($urandom), 6, -1);
        check1("first_ready_cycle", first_ready, 512);
        check1("first_valid_cycle", first_valid, 513);

        // Fill and steady state, width 6, pixels 0..29
        clear_caps();
        for (int p = 0; p < 30; p++) step(1'b1, p == 0, DW'(p), 6, p);
        step(1'b0, 1'b0, '0, 6, -1);
        lit = {8'd2, 8'd8, 8'd14, 8'd20};
        check1("pix20_data", cap_data[20], lit);
        check1("pix20_mask", cap_mask[20], 4'b1111);
        lit = REP ? {8'd1, 8'd1, 8'd1, 8'd7} : {8'd0, 8'd0, 8'd1, 8'd7};
        check1("pix7_data", cap_data[7], lit);
        check1("pix7_mask", cap_mask[7], 4'b0011);
        lit = REP ? {8'd3, 8'd3, 8'd3, 8'd3} : {8'd0, 8'd0, 8'd0, 8'd3};
        check1("pix3_data", cap_data[3], lit);
        for (int p = 0; p < 30; p++)
            check1($sformatf("pix%0d_eol", p), cap_eol[p], (p % 6) == 5);

        // SOF at col 3 of line 2
        clear_caps();
        for (int p = 0; p < 15; p++) step(1'b1, p == 0, DW'(p + 100), 6, -1);
        step(1'b1, 1'b1, 8'hAA, 6, 40);
        step(1'b1, 1'b0, 8'hAB, 6, 41);
        step(1'b0, 1'b0, '0, 6, -1);
        check1("midsof_mask", cap_mask[40], 4'b0001);
        check1("midsof_eol", cap_eol[40], 0);
        lit = REP ? {4{8'hAA}} : {24'h0, 8'hAA};
        check1("midsof_data", cap_data[40], lit);

        // Width clamp low: cfg_width=1 behaves as 2
        clear_caps();
        for (int p = 0; p < 6; p++) step(1'b1, p == 0, DW'(p + 50), 1, p);
        step(1'b0, 1'b0, '0, 1, -1);
        check1("w1_eol_col1", cap_eol[1], 1);
        check1("w1_line1_mask", cap_mask[2], 4'b0011);
        check1("w1_line2_mask", cap_mask[4], 4'b0111);

        // Width clamp high: cfg_width=1000 wraps after col 511
        clear_caps();
        for (int p = 0; p < 1030; p++) begin
            tag = (p == 510) ? 10 : (p == 511) ? 11 : (p == 512) ? 12 : -1;
            step(1'b1, p == 0, DW'($urandom), 1000, tag);
        end
        step(1'b0, 1'b0, '0, 6, -1);
        check1("w1000_eol_510", cap_eol[10], 0);
        check1("w1000_eol_511", cap_eol[11], 1);
        check1("w1000_wrap_mask", cap_mask[12], 4'b0011);

        // Randomized frames with gaps, random widths and occasional mid-line SOF
        for (int f = 0; f < 8; f++) begin
            int w;
            w = (f == 0) ? 1 : (f == 1) ? 2 : int'($urandom_range(2, 40));
            n = int'($urandom_range(30, 200));
            step(1'b1, 1'b1, DW'($urandom), w, -1);
            while (n > 0) begin
                bit v;
                bit s;
                v = ($urandom_range(0, 9) < 7);
                s = v && ($urandom_range(0, 59) == 0);
                step(v, s, DW'($urandom), int'($urandom_range(0, 1100)), -1);
                if (v) n--;
            end
        end

        // Reset mid-frame: output drops asynchronously, INIT restarts
        for (int p = 0; p < 9; p++) step(1'b1, p == 0, DW'(p), 6, -1);
        @(posedge clk);
        #2;
        check1("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check1("async_rst_valid", out_valid, 0);
        check1("async_rst_busy", init_busy, 1);
        check1("async_rst_ready", in_ready, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 530; i++)
            step(($urandom_range(0, 3) != 0), (i == 515), DW'($urandom), 5, -1);
        step(1'b0, 1'b0, '0, 5, -1);
        check1("reinit_first_ready", first_ready, 512);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the run cannot hang
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
